// File: rtl/aes256_key_sched_seq_if.sv
// Round-key port bundle between the AES-256 key schedule (slave) and its driver/consumer (master).
// Carries the key-load handshake and the round-key valid/ready stream.
interface aes256_key_sched_seq_if;
  logic [255:0] key_in;
  logic         key_load;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  modport master (
    output key_in, key_load, rk_ready,
    input  key_ready, rk_out, rk_idx, rk_last, rk_valid, busy
  );

  modport slave (
    input  key_in, key_load, rk_ready,
    output key_ready, rk_out, rk_idx, rk_last, rk_valid, busy
  );
endinterface

// File: rtl/aes256_key_sched_seq.sv
// Sequential AES-256 key schedule: one round key per accepted handshake (option: AES256_KEY_SCHED_ZEROIZE_EN).
// Latency: load accepted in cycle N gives rk0 valid in N+1; one key/cycle with rk_ready held high.
// Backpressure: rk_ready low holds rk_out/rk_idx/rk_last stable; key_load is ignored while busy.
module aes256_key_sched_seq #(
  parameter int ROUND_KEYS = 15
) (
  input logic                   clk,
  input logic                   rst_n,
  aes256_key_sched_seq_if.slave ks
);
  localparam logic [3:0] LAST_IDX = 4'(ROUND_KEYS - 1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q, state_d;
  logic [255:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [255:0] evolve0, evolve1;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Type 0 rotates and adds rcon on the newest word; type 1 only substitutes it.
  function automatic logic [255:0] evolve(input logic [255:0] k, input logic typ, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = typ ? sub_word(k[31:0]) : (sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0});
    n0 = k[255:224] ^ t;
    n1 = k[223:192] ^ n0;
    n2 = k[191:160] ^ n1;
    n3 = k[159:128] ^ n2;
    return {k[127:0], n0, n1, n2, n3};
  endfunction

  assign evolve0 = evolve(key_q, 1'b0, rcon_q);
  assign evolve1 = evolve(key_q, 1'b1, rcon_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    if (state_q == IDLE) begin
      if (ks.key_load) begin
        key_d   = ks.key_in;
        idx_d   = '0;
        rcon_d  = 8'h01;
        state_d = RUN;
      end
    end else if (ks.rk_ready) begin
      if (idx_q == LAST_IDX) begin
        state_d = IDLE;
`ifdef AES256_KEY_SCHED_ZEROIZE_EN
        key_d   = '0;
`endif
      end else begin
        key_d = idx_q[0] ? evolve1 : evolve0;
        if (idx_q[0]) rcon_d = rcon_q << 1;
        idx_d = idx_q + 4'd1;
      end
    end
  end

  assign ks.key_ready = (state_q == IDLE);
  assign ks.busy      = (state_q == RUN);
  assign ks.rk_valid  = (state_q == RUN);
  assign ks.rk_out    = key_q[255:128];
  assign ks.rk_idx    = idx_q;
  assign ks.rk_last   = (state_q == RUN) && (idx_q == LAST_IDX);
endmodule

// File: tb/tb_aes256_key_sched_seq.sv
// Bench for aes256_key_sched_seq: FIPS-197 vectors, random backpressure, load-in-RUN, mid-schedule reset,
// truncated ROUND_KEYS=5 instance; reference expansion built from GF(2^8) arithmetic.
module tb_aes256_key_sched_seq;
  logic clk;
  logic rst_n;

  aes256_key_sched_seq_if ks ();
  aes256_key_sched_seq_if ks5 ();

  aes256_key_sched_seq #(.ROUND_KEYS(15)) dut (.clk(clk), .rst_n(rst_n), .ks(ks));
  aes256_key_sched_seq #(.ROUND_KEYS(5))  dut5 (.clk(clk), .rst_n(rst_n), .ks(ks5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] FIPS_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    int           idx;
    logic [127:0] exp;
    logic [127:0] mask;
  } vec_t;

  int           n_checks;
  int           n_fail;
  logic [7:0]   sb [256];
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];
  vec_t         vecs [7];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[b] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Textbook word-wise key expansion: 60 words, Nk = 8.
  task automatic model_expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0)      t = subw({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
      else if (i % 8 == 4) t = subw(t);
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  function automatic logic [127:0] idle_rk(input logic [127:0] last_rk);
`ifdef AES256_KEY_SCHED_ZEROIZE_EN
    return (last_rk & 128'h0);
`else
    return last_rk;
`endif
  endfunction

  task automatic run_sched(input logic [255:0] key, input bit rand_rdy, input bit glitch, input int rst_at);
    int e, cyc;
    bit prev_stall;
    logic [127:0] prev_out;
    logic [3:0] prev_idx;
    model_expand(key);
    @(negedge clk);
    chk("key_ready_before_load", ks.key_ready, 1);
    ks.key_in = key; ks.key_load = 1'b1; ks.rk_ready = 1'b0;
    @(negedge clk);
    ks.key_load = 1'b0;
    chk("rk0_valid_latency", ks.rk_valid, 1);
    e = 0; cyc = 0; prev_stall = 0; prev_out = '0; prev_idx = '0;
    while (e < 15) begin
      if (cyc > 400) begin
        chk("schedule_timeout", 128'(e), 128'd15);
        break;
      end
      if (rst_at == e) begin
        rst_n = 1'b0; ks.rk_ready = 1'b0; ks.key_load = 1'b0;
        @(negedge clk);
        chk("rst_rk_valid", ks.rk_valid, 0);
        chk("rst_key_ready", ks.key_ready, 1);
        chk("rst_busy", ks.busy, 0);
        chk("rst_rk_idx", ks.rk_idx, 0);
        chk("rst_rk_out", ks.rk_out, 0);
        rst_n = 1'b1;
        return;
      end
      chk("rk_valid_run", ks.rk_valid, 1);
      chk("key_ready_run", ks.key_ready, 0);
      chk("busy_run", ks.busy, 1);
      chk("rk_out", ks.rk_out, exp_rk[e]);
      chk("rk_idx", ks.rk_idx, 128'(e));
      chk("rk_last", ks.rk_last, 128'(e == 14));
      if (prev_stall) begin
        chk("stall_rk_out", ks.rk_out, prev_out);
        chk("stall_rk_idx", ks.rk_idx, prev_idx);
      end
      if (glitch) begin
        ks.key_in = ~key;
        ks.key_load = 1'($urandom_range(0, 1));
      end
      ks.rk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ks.rk_ready) begin
        got_rk[e] = ks.rk_out;
        e++;
        prev_stall = 0;
      end else begin
        prev_stall = 1;
        prev_out = ks.rk_out;
        prev_idx = ks.rk_idx;
      end
      @(negedge clk);
      cyc++;
    end
    ks.key_load = 1'b0; ks.rk_ready = 1'b0;
    chk("post_rk_valid", ks.rk_valid, 0);
    chk("post_key_ready", ks.key_ready, 1);
    chk("post_busy", ks.busy, 0);
    chk("post_rk_last", ks.rk_last, 0);
    chk("post_rk_out", ks.rk_out, idle_rk(exp_rk[14]));
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    vecs[0] = '{0,  128'h603deb1015ca71be2b73aef0857d7781, {128{1'b1}}};
    vecs[1] = '{1,  128'h1f352c073b6108d72d9810a30914dff4, {128{1'b1}}};
    vecs[2] = '{2,  128'h9ba354118e6925afa51a8b5f2067fcde, {128{1'b1}}};
    vecs[3] = '{3,  {32'ha8b09c1a, 96'h0}, {{32{1'b1}}, 96'h0}};
    vecs[4] = '{4,  {32'hd59aecb8, 96'h0}, {{32{1'b1}}, 96'h0}};
    vecs[5] = '{5,  {32'hb5a9328a, 96'h0}, {{32{1'b1}}, 96'h0}};
    vecs[6] = '{14, 128'hfe4890d1e6188d0b046df344706c631e, {128{1'b1}}};
    build_sbox();

    ks.key_in = '0; ks.key_load = 1'b0; ks.rk_ready = 1'b0;
    ks5.key_in = '0; ks5.key_load = 1'b0; ks5.rk_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_key_ready", ks.key_ready, 1);
    chk("reset_rk_valid", ks.rk_valid, 0);
    chk("reset_rk_out", ks.rk_out, 0);
    chk("reset_rk_idx", ks.rk_idx, 0);
    chk("reset_rk_last", ks.rk_last, 0);
    chk("reset_busy", ks.busy, 0);
    rst_n = 1'b1;

    run_sched(FIPS_KEY, 0, 0, -1);
    for (int i = 0; i < 7; i++)
      chk($sformatf("fips_vec_rk%0d", vecs[i].idx), got_rk[vecs[i].idx] & vecs[i].mask, vecs[i].exp & vecs[i].mask);

    run_sched(FIPS_KEY, 1, 0, -1);
    run_sched(FIPS_KEY, 1, 1, -1);
    run_sched(rand_key(), 1, 1, -1);
    run_sched(FIPS_KEY, 0, 0, 7);
    run_sched(FIPS_KEY, 0, 0, -1);
    for (int k = 0; k < 3; k++) run_sched(rand_key(), 1, 0, -1);

    // Truncated schedule: five keys then back to idle.
    model_expand(FIPS_KEY);
    @(negedge clk);
    ks5.key_in = FIPS_KEY; ks5.key_load = 1'b1;
    @(negedge clk);
    ks5.key_load = 1'b0; ks5.rk_ready = 1'b1;
    for (int e = 0; e < 5; e++) begin
      chk("rk5_valid", ks5.rk_valid, 1);
      chk("rk5_out", ks5.rk_out, exp_rk[e]);
      chk("rk5_idx", ks5.rk_idx, 128'(e));
      chk("rk5_last", ks5.rk_last, 128'(e == 4));
      @(negedge clk);
    end
    ks5.rk_ready = 1'b0;
    chk("rk5_post_valid", ks5.rk_valid, 0);
    chk("rk5_post_key_ready", ks5.key_ready, 1);
    chk("rk5_post_rk_out", ks5.rk_out, idle_rk(exp_rk[4]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
